branch_redirect_unit: RTL

EX-stage branch/jump resolution block: the producer side of the fetch redirect path that the next-PC select logic consumes. It evaluates conditional branches, JAL and JALR against the resolved operands and issues a registered redirect (target PC plus valid) to fetch, holding it until fetch accepts it. It also drives IF/ID and ID/EX flush signals for the wrong-path window and counts taken redirects. The static prediction is always not-taken, so every taken control transfer produces a redirect.

---
 rtl/branch_redirect_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/branch_redirect_unit.sv
//------------------------------------------------------------------------------
// Module      : branch_redirect_unit
// Description : EX-stage branch/jump resolution; issues a held fetch redirect,
//               drives wrong-path flushes and counts taken redirects.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_redirect_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        ex_stall,
    output logic        target_misaligned,
    output logic [31:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic        r_ex_stall;
    logic        r_target_misaligned;
    logic [31:0] r_redirect_count;

    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_cond;
    logic        w_taken;
    logic [31:0] w_sum_pc;
    logic [31:0] w_sum_rs1;
    logic [31:0] w_target;

    assign w_eq      = (ex_rs1 == ex_rs2);
    assign w_lt      = ($signed(ex_rs1) < $signed(ex_rs2));
    assign w_ltu     = (ex_rs1 < ex_rs2);
    assign w_sum_pc  = ex_pc + ex_imm;
    assign w_sum_rs1 = ex_rs1 + ex_imm;

    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = !w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = !w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    // jalr > jal > branch when decode asserts more than one kind
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_sum_pc;
        if (ex_is_jalr) begin
            w_taken  = ex_valid;
            w_target = {w_sum_rs1[31:1], 1'b0};
        end else if (ex_is_jal) begin
            w_taken  = ex_valid;
        end else if (ex_is_branch) begin
            w_taken  = ex_valid && w_cond;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_taken)            w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (fetch_ready)        w_state_nxt = ST_FLUSH;
            ST_FLUSH:    if (r_flush_cnt == 3'd0) w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= ST_IDLE;
            r_flush_cnt         <= 3'd0;
            r_redirect_valid    <= 1'b0;
            r_redirect_pc       <= 32'd0;
            r_flush             <= 1'b0;
            r_ex_stall          <= 1'b0;
            r_target_misaligned <= 1'b0;
            r_redirect_count    <= 32'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_redirect_valid <= (w_state_nxt == ST_REDIRECT);
            r_ex_stall       <= (w_state_nxt == ST_REDIRECT);
            r_flush          <= (w_state_nxt != ST_IDLE);

            if (r_state == ST_IDLE && w_taken) begin
                r_redirect_pc       <= w_target;
                r_redirect_count    <= r_redirect_count + 32'd1;
                r_target_misaligned <= w_target[1];
            end else begin
                r_target_misaligned <= 1'b0;
            end

            if (r_state == ST_REDIRECT && fetch_ready) begin
                r_flush_cnt <= c_flush_load;
            end else if (r_state == ST_FLUSH && r_flush_cnt != 3'd0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    assign redirect_valid    = r_redirect_valid;
    assign redirect_pc       = r_redirect_pc;
    assign flush_if_id       = r_flush;
    assign flush_id_ex       = r_flush;
    assign ex_stall          = r_ex_stall;
    assign target_misaligned = r_target_misaligned;
    assign redirect_count    = r_redirect_count;

endmodule

`default_nettype wire
